instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage sitting directly upstream of `decode_instruction`. Holds the program counter, issues word reads to a synchronous instruction memory with 1-cycle read latency, and buffers returned 33-bit instruction words in a 2-entry queue. Delivers instructions to decode over a valid/ready handshake and accepts a branch redirect from execute, squashing all older fetched words.

## Interface

- `INSTRUCTION_WIDTH`, 33: instruction word width, bits [32:28] opcode, [27:24] reg_dest, [23:20] reg_source_1, [19:16] reg_source_2, [15:0] immediate.
- `PC_WIDTH`, 16: word-address width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fetch_enable`  in  1  when 0, no new memory requests are issued.
- `imem_en`  out  1  read request this cycle.
- `imem_addr`  out  PC_WIDTH  read word address.
- `imem_rdata`  in  INSTRUCTION_WIDTH  data for the request issued in the previous cycle.
- `instruction`  out  INSTRUCTION_WIDTH  queue head word, to decoder.
- `instr_pc`  out  PC_WIDTH  address of `instruction`.
- `instr_valid`  out  1  head valid.
- `instr_ready`  in  1  decoder accepts head.
- `redirect_valid`  in  1  branch taken; flush and refetch.
- `redirect_pc`  in  PC_WIDTH  branch target.

## Operation

- State: `pc`, 2-entry queue of {pc, word} with count 0..2, `inflight` bit, `inflight_pc`.
- Pop = `instr_valid & instr_ready`.
- Issue condition: `fetch_enable` and (count + inflight − pop) < 2. Invariant: count + inflight ≤ 2.
- `imem_en` = issue condition. `imem_addr` = `redirect_valid ? redirect_pc : pc`.
- On issue: `inflight_pc` ← `imem_addr`, `inflight` ← 1, `pc` ← `imem_addr` + 1 mod 2^PC_WIDTH (0xFFFF wraps to 0x0000). Without issue, `inflight` ← 0 and `pc` ← `imem_addr`.
- Return: when `inflight` = 1 and `redirect_valid` = 0, {`inflight_pc`, `imem_rdata`} is pushed at the end of the cycle. Push and pop in the same cycle are both honoured.
- Redirect cycle:
  - Queue is flushed (count ← 0).
  - The return arriving this cycle is discarded.
  - `instr_valid` is forced to 0, so no pop occurs.
  - Issue condition is evaluated with count = 0 and inflight = 0, so a request to `redirect_pc` is issued if `fetch_enable` = 1.
- `fetch_enable` low: the outstanding request still returns and is pushed. Queue contents stay deliverable.
- Stall (`instr_ready` = 0): the head and its `instr_pc` hold stable. Issue stops once count + inflight = 2. No word is dropped or duplicated.
- `instr_valid` = (count ≠ 0) & !`redirect_valid`. `instruction`/`instr_pc` show the queue head. When count = 0 they hold their last value (0 after reset).

## Timing

- Reset values: `instr_valid` 0, `instruction` 0, `instr_pc` 0, `imem_en` 0 during reset, `pc` = RESET_PC, count 0, `inflight` 0.
- First request is issued in the first cycle after `rst_n` rises, with `imem_addr` = RESET_PC.
- Fetch-to-valid latency: request in cycle T, data in T+1, `instr_valid` in T+2.
- Throughput: 1 instruction/cycle with `instr_ready` held high (steady state count = 1, inflight = 1).
- Redirect latency: `redirect_valid` in cycle T, target word valid in T+2. No word fetched before T is ever presented after T.
- Reset asserted mid-operation clears all state in the same edge. Any `imem_rdata` for a pre-reset request is ignored.
- Simultaneous redirect and stall: redirect wins.

## Test plan

- Reset/boot: memory[0..3] = 0x011000010, 0x012000020, 0x052210000, 0x030100030, `instr_ready` = 1 → `instr_valid` rises 2 cycles after reset release. The four words appear on consecutive cycles with `instr_pc` 0, 1, 2, 3.
- Backpressure: `instr_ready` = 0 for 5 cycles after the first valid word → the head holds 0x011000010 with pc 0 and `imem_en` drops after count + inflight = 2. On release, words 1, 2, 3 follow with no gaps, loss or duplicates.
- Redirect: at pc 5 word 0x0E130FFFD, assert `redirect_valid` with `redirect_pc` = 2 for 1 cycle → `instr_valid` = 0 in that cycle and the next. Then pc 2, 3, 4… follow, and no words from pc 6/7 are ever presented.
- Wrap: RESET_PC = 0xFFFE → `instr_pc` sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `fetch_enable` low for 3 cycles mid-stream → the in-flight word is delivered and no `imem_en` is asserted during the low cycles. Fetch resumes at the next sequential pc.
- Mid-stream reset with `instr_ready` = 0 and a full queue → all outputs return to reset values in the next cycle. Fetch restarts at RESET_PC and no stale word is presented.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, decode handshake and
// branch redirect from execute. The fetch stage is the master side.
`timescale 1ns/1ps
interface instruction_fetch_if #(
  parameter int unsigned INSTRUCTION_WIDTH = 33,
  parameter int unsigned PC_WIDTH          = 16
);
  logic                         fetch_enable;
  logic                         imem_en;
  logic [PC_WIDTH-1:0]          imem_addr;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]          instr_pc;
  logic                         instr_valid;
  logic                         instr_ready;
  logic                         redirect_valid;
  logic [PC_WIDTH-1:0]          redirect_pc;

  modport master (
    input  fetch_enable, imem_rdata, instr_ready, redirect_valid, redirect_pc,
    output imem_en, imem_addr, instruction, instr_pc, instr_valid
  );

  modport slave (
    output fetch_enable, imem_rdata, instr_ready, redirect_valid, redirect_pc,
    input  imem_en, imem_addr, instruction, instr_pc, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, 1-cycle-latency imem requests,
// 2-entry {pc, word} queue feeding decode, branch redirect with squash.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int unsigned         INSTRUCTION_WIDTH = 33,
  parameter int unsigned         PC_WIDTH          = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  instruction_fetch_if.master  bus
);

  logic [PC_WIDTH-1:0]          pc;
  logic                         inflight;
  logic [PC_WIDTH-1:0]          inflight_pc;
  logic [1:0]                   count;
  logic [PC_WIDTH-1:0]          q_pc   [2];
  logic [INSTRUCTION_WIDTH-1:0] q_word [2];

  logic                         valid;
  logic                         pop;
  logic                         push;
  logic                         issue;
  logic [PC_WIDTH-1:0]          addr;
  logic [1:0]                   eff_count;
  logic                         eff_inflight;
  logic [2:0]                   occupancy;

  // Handshake, return and issue decisions; a redirect makes the queue and the
  // in-flight request look empty so the target is requested immediately.
  always_comb begin
    valid        = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    issue        = 1'b0;
    addr         = pc;
    eff_count    = count;
    eff_inflight = inflight;
    occupancy    = '0;

    if (bus.redirect_valid) begin
      addr         = bus.redirect_pc;
      eff_count    = '0;
      eff_inflight = 1'b0;
    end
    valid     = (count != 2'd0) && !bus.redirect_valid;
    pop       = valid && bus.instr_ready;
    push      = inflight && !bus.redirect_valid;
    occupancy = {1'b0, eff_count} + {2'b00, eff_inflight} - {2'b00, pop};
    issue     = rst_n && bus.fetch_enable && (occupancy < 3'd2);
  end

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = valid;
  // Entry 0 is the head; it is left untouched when the queue drains so the
  // outputs hold the last delivered word while empty.
  assign bus.instruction = q_word[0];
  assign bus.instr_pc    = q_pc[0];

  // PC and in-flight request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      pc          <= addr + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= addr;
    end else begin
      pc          <= addr;
      inflight    <= 1'b0;
    end
  end

  // Two-entry shift queue: push lands behind the head, pop shifts forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
      q_word[0] <= '0;
      q_word[1] <= '0;
    end else if (bus.redirect_valid) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q_pc[0]   <= inflight_pc;
            q_word[0] <= bus.imem_rdata;
          end else begin
            q_pc[1]   <= inflight_pc;
            q_word[1] <= bus.imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            q_pc[0]   <= q_pc[1];
            q_word[0] <= q_word[1];
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          // count + inflight <= 2 means a push never meets a full queue.
          if (count == 2'd1) begin
            q_pc[0]   <= inflight_pc;
            q_word[0] <= bus.imem_rdata;
          end else begin
            q_pc[0]   <= q_pc[1];
            q_word[0] <= q_word[1];
            q_pc[1]   <= inflight_pc;
            q_word[1] <= bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
